ps2_key_decoder: RTL

Receives the raw PS/2 keyboard clock/data lines and turns them into complete key events: {extended, release, scan code}. Each event is held on a valid/ack handshake. The block frames each 11-bit packet (start, 8 data LSB-first, odd parity, stop) with glitch filtering and an inter-bit timeout. It then folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into the event. It sits directly downstream of the board's PS2_CLK/PS2_DAT pins and feeds HEX/LEDR display logic or a keyboard-driven controller.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_frame_rx.sv | 152 +++++++++++++++
 rtl/ps2_key_decoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 keyboard decoder.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : prefix bytes folded into key events
//   frame_state_e                   : bit-level frame receiver states
//   prefix_state_e                  : prefix tracking states
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  typedef enum logic [1:0] {
    PfxBase,
    PfxExt,
    PfxRel,
    PfxExtRel
  } prefix_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: synchronizes and glitch-filters the raw clock/data lines,
// frames 11-bit packets (start, 8 data LSB-first, odd parity, stop) and aborts
// a frame when no falling edge is seen for TIMEOUT_CYCLES.
//   CLOCK_50     : system clock
//   Resetn       : synchronous active-low reset
//   ps2_clk_i    : raw keyboard clock (asynchronous)
//   ps2_dat_i    : raw keyboard data (asynchronous)
//   byte_o       : received byte, valid with byte_valid_o
//   byte_valid_o : one-cycle pulse for a well-formed frame
//   frame_err_o  : one-cycle pulse on parity, stop or timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimW  = $clog2(TIMEOUT_CYCLES + 1);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]       sync1_q, sync2_q, filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q [2];
  logic [FiltW-1:0] fcnt_d [2];
  logic             clk_prev_q, fall_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
        if (fcnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [TimW-1:0] tcnt_q, tcnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           bvalid_q, bvalid_d, ferr_q, ferr_d;
  logic           dat;

  assign dat = filt_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    byte_d    = byte_q;
    bvalid_d  = 1'b0;
    ferr_d    = 1'b0;
    tcnt_d    = (state_q == StIdle || fall_q) ? '0 : tcnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (fall_q && !dat) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall_q) begin
          shreg_d   = {dat, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall_q) begin
          par_d   = dat;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall_q) begin
          if ((^shreg_q ^ par_q) && dat) begin
            bvalid_d = 1'b1;
            byte_d   = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !fall_q && tcnt_q == TimW'(TIMEOUT_CYCLES - 1)) begin
      ferr_d  = 1'b1;
      state_d = StIdle;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      byte_q     <= 8'h00;
      bvalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= {ps2_dat_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= filt_q[0];
      // Registered so the fall is flagged one cycle after the filtered 1->0.
      fall_q     <= clk_prev_q & ~filt_q[0];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      byte_q     <= byte_d;
      bvalid_q   <= bvalid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bvalid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard key-event decoder: receives bytes via ps2_frame_rx, folds the
// E0 (extended) and F0 (break) prefixes into one event and holds it on a
// valid/ack handshake.
//   CLOCK_50, Resetn           : clock, synchronous active-low reset
//   PS2_CLK, PS2_DAT           : raw keyboard lines
//   key_code/key_ext/key_release : held event contents
//   key_valid, key_ack         : event handshake
//   frame_err                  : pulse on a malformed or timed-out frame
//   overrun                    : pulse when an event is dropped
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       frame_err,
  output logic       overrun
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLOCK_50    (CLOCK_50),
    .Resetn      (Resetn),
    .ps2_clk_i   (PS2_CLK),
    .ps2_dat_i   (PS2_DAT),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  prefix_state_e pfx_q, pfx_d;
  logic          emit, cur_ext, cur_rel;

  always_comb begin
    pfx_d   = pfx_q;
    emit    = 1'b0;
    cur_ext = (pfx_q == PfxExt) || (pfx_q == PfxExtRel);
    cur_rel = (pfx_q == PfxRel) || (pfx_q == PfxExtRel);
    if (rx_err) begin
      // A broken sequence must not produce an event with stale prefixes.
      pfx_d = PfxBase;
    end else if (rx_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        pfx_d = cur_rel ? PfxExtRel : PfxExt;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        pfx_d = cur_ext ? PfxExtRel : PfxRel;
      end else begin
        emit  = 1'b1;
        pfx_d = PfxBase;
      end
    end
  end

  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d, rel_q, rel_d, valid_q, valid_d, ovr_q, ovr_d;

  always_comb begin
    code_d  = code_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && key_ack) valid_d = 1'b0;
    if (emit) begin
      // An ack in the emit cycle frees the slot, so the new event is taken.
      if (!valid_q || key_ack) begin
        code_d  = rx_byte;
        ext_d   = cur_ext;
        rel_d   = cur_rel;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      pfx_q   <= PfxBase;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pfx_q   <= pfx_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign key_code    = code_q;
  assign key_ext     = ext_q;
  assign key_release = rel_q;
  assign key_valid   = valid_q;
  assign frame_err   = rx_err;
  assign overrun     = ovr_q;

endmodule
